// File: rtl/banco_arbiter.sv
// Arbitrates the single-port colour bank between queued keypad writes and VGA reads.
// Optional macro ARB_WR_FORWARD_EN forwards uncommitted queue data to VGA reads.
module banco_arbiter #(
   parameter int unsigned AW         = 4,
   parameter int unsigned DW         = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_req_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   output logic          wr_full_o,
   output logic          wr_overflow_o,
   input  logic          rd_req_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic          rd_gnt_o,
   output logic          rd_valid_o,
   output logic [DW-1:0] rd_data_o,
   output logic [AW-1:0] bank_addr_o,
   output logic          bank_we_o,
   output logic [DW-1:0] bank_wdata_o,
   input  logic [DW-1:0] bank_rdata_i
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
   localparam logic [CW-1:0] Depth     = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] q_addr_q [FIFO_DEPTH];
   logic [DW-1:0] q_data_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          full_q, ovf_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] rd_src;
   logic          empty, do_rd, do_wr, push;

   assign empty = (count_q == '0);

   // Reads win unless the queue has been starved for STARVE_MAX grants.
   always_comb begin
      do_rd   = 1'b0;
      do_wr   = 1'b0;
      state_d = StIdle;
      if (!rst_i) begin
         if (rd_req_i && (starve_q < StarveMax)) begin
            do_rd   = 1'b1;
            state_d = StRd;
         end else if (!empty) begin
            do_wr   = 1'b1;
            state_d = StWr;
         end
      end
   end

   always_comb begin
      push    = wr_req_i && !rst_i && (!full_q || do_wr);
      count_d = count_q;
      if (push && !do_wr) begin
         count_d = count_q + 1'b1;
      end else if (!push && do_wr) begin
         count_d = count_q - 1'b1;
      end
      if (do_wr || empty) begin
         starve_d = '0;
      end else if (do_rd && (starve_q < StarveMax)) begin
         starve_d = starve_q + 1'b1;
      end else begin
         starve_d = starve_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_addr_q[wr_ptr_q] <= wr_addr_i;
         q_data_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         full_q   <= (count_d == Depth);
         addr_q   <= bank_addr_o;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_wr) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_req_i && !push) ovf_q <= 1'b1;
         if (rd_valid_o) rd_data_q <= rd_data_o;
      end
   end

`ifdef ARB_WR_FORWARD_EN
   logic          fwd_hit, fwd_hit_q;
   logic [DW-1:0] fwd_data, fwd_data_q;

   // Later (younger) matches overwrite earlier ones.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if ((CW'(i) < count_q) && (q_addr_q[rd_ptr_q + PW'(i)] == rd_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = q_data_q[rd_ptr_q + PW'(i)];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else if (do_rd) begin
         fwd_hit_q  <= fwd_hit;
         fwd_data_q <= fwd_data;
      end
   end

   assign rd_src = fwd_hit_q ? fwd_data_q : bank_rdata_i;
`else
   assign rd_src = bank_rdata_i;
`endif

   assign rd_gnt_o      = do_rd;
   assign rd_valid_o    = (state_q == StRd);
   assign rd_data_o     = rd_valid_o ? rd_src : rd_data_q;
   assign bank_we_o     = do_wr;
   assign bank_wdata_o  = q_data_q[rd_ptr_q];
   assign bank_addr_o   = do_rd ? rd_addr_i : (do_wr ? q_addr_q[rd_ptr_q] : addr_q);
   assign wr_full_o     = full_q;
   assign wr_overflow_o = ovf_q;

endmodule

// File: tb/tb_banco_arbiter.sv
// Scoreboard bench for banco_arbiter: queue-based reference model plus bank memory model.
// Honours ARB_WR_FORWARD_EN when the design is built with it.
module tb_banco_arbiter;

   localparam int DEPTH = 4;
   localparam int SMAX  = 8;

   logic       clk = 1'b0;
   logic       rst, wr_req, rd_req;
   logic [3:0] wr_addr, rd_addr, bank_addr;
   logic [2:0] wr_data, rd_data, bank_wdata, bank_rdata;
   logic       wr_full, wr_overflow, rd_gnt, rd_valid, bank_we;

   always #5 clk = ~clk;

   banco_arbiter #(.AW(4), .DW(3), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk_i(clk), .rst_i(rst),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_full_o(wr_full), .wr_overflow_o(wr_overflow),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
      .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .bank_addr_o(bank_addr), .bank_we_o(bank_we), .bank_wdata_o(bank_wdata),
      .bank_rdata_i(bank_rdata)
   );

   // Environment: the BancoRegistro the arbiter drives.
   logic [2:0] bmem [16];
   initial for (int i = 0; i < 16; i++) bmem[i] = 3'd0;
   always @(posedge clk) begin
      if (bank_we) bmem[bank_addr] <= bank_wdata;
      bank_rdata <= bmem[bank_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model state
   typedef struct {logic [3:0] a; logic [2:0] d;} ent_t;
   ent_t       q[$];
   ent_t       wr_exp[$];
   logic [2:0] rd_exp[$];
   logic [2:0] mmem [16];
   int         starve = 0;
   bit         ovf = 0, prev_gnt = 0, armed = 0;
   initial for (int i = 0; i < 16; i++) mmem[i] = 3'd0;

   always @(negedge clk) begin
      if (armed) begin
         bit gnt, wr;
         logic [2:0] d;
         ent_t e;
         gnt = !rst && rd_req && (starve < SMAX);
         wr  = !rst && !gnt && (q.size() != 0) && !(rd_req && starve < SMAX);
         check("rd_gnt", rd_gnt, gnt);
         check("bank_we", bank_we, wr);
         check("rd_valid", rd_valid, prev_gnt);
         check("wr_full", wr_full, q.size() == DEPTH);
         check("wr_overflow", wr_overflow, ovf);
         if (rst) begin
            q.delete();
            starve   = 0;
            ovf      = 0;
            prev_gnt = 0;
         end else begin
            bit was_empty;
            was_empty = (q.size() == 0);
            if (gnt) begin
               d = mmem[rd_addr];
`ifdef ARB_WR_FORWARD_EN
               foreach (q[i]) if (q[i].a == rd_addr) d = q[i].d;
`endif
               rd_exp.push_back(d);
            end
            if (wr) begin
               e = q.pop_front();
               mmem[e.a] = e.d;
               wr_exp.push_back(e);
            end
            if (wr || was_empty) starve = 0;
            else if (gnt && starve < SMAX) starve++;
            if (wr_req) begin
               if (q.size() < DEPTH) begin
                  e.a = wr_addr;
                  e.d = wr_data;
                  q.push_back(e);
               end else begin
                  ovf = 1;
               end
            end
            prev_gnt = gnt;
         end
      end
   end

   // Monitor: pops expectations when the DUT presents a bank write or read data.
   always @(negedge clk) begin
      #2;
      if (armed && bank_we) begin
         if (wr_exp.size() == 0) begin
            check("unexpected_bank_we", 1, 0);
         end else begin
            ent_t e;
            e = wr_exp.pop_front();
            check("bank_addr", bank_addr, e.a);
            check("bank_wdata", bank_wdata, e.d);
         end
      end
      if (armed && rd_valid) begin
         if (rd_exp.size() == 0) begin
            check("unexpected_rd_valid", 1, 0);
         end else begin
            check("rd_data", rd_data, rd_exp.pop_front());
         end
      end
   end

   task automatic drive(input logic r, input logic rq, input logic [3:0] ra,
                        input logic wq, input logic [3:0] wa, input logic [2:0] wd);
      rst = r; rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rq);
      for (int i = 0; i < n; i++) drive(0, rq, 4'($urandom_range(0, 15)), 0, 4'd0, 3'd0);
   endtask

   initial begin
      rst = 1; rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
      repeat (2) @(posedge clk);
      #1;
      armed = 1;
      rst = 0;
      idle(2, 0);
      // Single write drains on an idle bus.
      drive(0, 0, 4'd0, 1, 4'd5, 3'b110);
      idle(3, 0);
      // One queued write under continuous reads: forced write after the limit.
      drive(0, 1, 4'd5, 1, 4'd3, 3'd2);
      idle(14, 1);
      idle(3, 0);
      // Five back-to-back writes under reads: fifth is dropped.
      for (int i = 0; i < 5; i++) drive(0, 1, 4'd1, 1, 4'(i + 8), 3'(i + 1));
      idle(6, 1);
      idle(8, 0);
      drive(1, 0, 4'd0, 0, 4'd0, 3'd0);
      idle(2, 0);
      // Duplicate address queued then read before drain.
      drive(0, 1, 4'd7, 1, 4'd2, 3'd1);
      drive(0, 1, 4'd7, 1, 4'd2, 3'd4);
      drive(0, 1, 4'd2, 0, 4'd0, 3'd0);
      idle(2, 1);
      idle(6, 0);
      // Reset right after a grant with writes pending.
      for (int i = 0; i < 3; i++) drive(0, 1, 4'd9, 1, 4'(i), 3'(7 - i));
      drive(1, 1, 4'd9, 0, 4'd0, 3'd0);
      idle(4, 0);
      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         int pr;
         pr = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 50 : 10);
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pr,
               4'($urandom_range(0, 15)), $urandom_range(0, 99) < 35,
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end
      idle(12, 0);
      @(negedge clk);
      #3;
      check("wr_exp_drained", wr_exp.size(), 0);
      check("rd_exp_drained", rd_exp.size(), 0);
      check("model_queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
